// File: rtl/sti_dac_gen_pkg.sv
// Shared types and helpers for the serial transmitter / data arrange controller.
package sti_dac_gen_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, FILL, DONE} state_t;

  function automatic int unsigned byte_bits(input int unsigned len);
    return (len + 1) * BYTE_W;
  endfunction

  // Checkerboard: (row + column) odd selects the even bank.
  function automatic logic bank_even(input int unsigned idx, input int unsigned row_bytes);
    return (((idx / row_bytes) + (idx % row_bytes)) % 2) != 0;
  endfunction

  function automatic int unsigned bank_addr(input int unsigned idx);
    return idx >> 1;
  endfunction

endpackage

// File: rtl/sti_dac_gen_if.sv
// Word load / serial output / bank write bundle of sti_dac_gen.
interface sti_dac_gen_if
  import sti_dac_gen_pkg::*;
#(
  parameter int DIN_W      = 16,
  parameter int MAX_BYTES  = 4,
  parameter int NUM_PAGES  = 4,
  parameter int PAGE_BYTES = 64
);
  localparam int LEN_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int ADDR_W = $clog2(PAGE_BYTES / 2);

  logic                   load;
  logic                   pi_ready;
  logic [DIN_W-1:0]       pi_data;
  logic [LEN_W-1:0]       pi_length;
  logic                   pi_fill;
  logic                   pi_msb;
  logic                   pi_low;
  logic                   pi_end;
  logic                   so_data;
  logic                   so_valid;
  logic                   so_parity;
  logic [BYTE_W-1:0]      oem_dataout;
  logic [ADDR_W-1:0]      oem_addr;
  logic [2*NUM_PAGES-1:0] oem_wr;
  logic                   oem_finish;

  modport master (
    output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
    input  pi_ready, so_data, so_valid, so_parity, oem_dataout, oem_addr, oem_wr, oem_finish
  );

  modport slave (
    input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
    output pi_ready, so_data, so_valid, so_parity, oem_dataout, oem_addr, oem_wr, oem_finish
  );

endinterface

// File: rtl/sti_dac_gen_arrange.sv
// Byte packer and checkerboard bank writer with end-of-stream zero fill.
module sti_dac_gen_arrange
  import sti_dac_gen_pkg::*;
#(
  parameter int NUM_PAGES  = 4,
  parameter int PAGE_BYTES = 64,
  parameter int ROW_BYTES  = 8,
  parameter int ADDR_W     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bit_valid,
  input  logic                   bit_data,
  input  logic                   fill,
  input  logic                   clear,
  input  logic                   done,
  output logic [BYTE_W-1:0]      dataout,
  output logic [ADDR_W-1:0]      addr,
  output logic [2*NUM_PAGES-1:0] wr,
  output logic                   finish,
  output logic                   last_write
);
  localparam int TOTAL = NUM_PAGES * PAGE_BYTES;
  localparam int G_W   = $clog2(TOTAL);
  localparam int PB_W  = $clog2(PAGE_BYTES);

  logic [BYTE_W-2:0]      byte_reg;
  logic [2:0]             bit_cnt_reg;
  logic [G_W-1:0]         g_reg;
  logic [PB_W-1:0]        in_page;
  logic [2*NUM_PAGES-1:0] wr_next;
  logic                   byte_done;
  logic                   write_now;
  logic                   even_bank;

  assign byte_done  = bit_valid && (bit_cnt_reg == 3'd7) && !done;
  assign write_now  = byte_done || (fill && !done);
  assign last_write = write_now && (g_reg == G_W'(TOTAL - 1));
  assign in_page    = g_reg[PB_W-1:0];
  assign even_bank  = bank_even(32'(in_page), ROW_BYTES);

  generate
    for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_strobe
      assign wr_next[2*gi]   = write_now && !even_bank && ((g_reg >> PB_W) == G_W'(gi));
      assign wr_next[2*gi+1] = write_now &&  even_bank && ((g_reg >> PB_W) == G_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_reg    <= '0;
      bit_cnt_reg <= '0;
      g_reg       <= '0;
      wr          <= '0;
      dataout     <= '0;
      addr        <= '0;
      finish      <= 1'b0;
    end else begin
      wr <= wr_next;
      if (write_now) begin
        dataout <= fill ? '0 : {byte_reg, bit_data};
        addr    <= ADDR_W'(bank_addr(32'(in_page)));
        g_reg   <= g_reg + G_W'(1);
      end
      // A pending partial byte is dropped when the stream ends.
      if (clear) begin
        byte_reg    <= '0;
        bit_cnt_reg <= '0;
      end else if (bit_valid && !done) begin
        byte_reg    <= {byte_reg[BYTE_W-3:0], bit_data};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end
      finish <= finish || done;
    end
  end

endmodule

// File: rtl/sti_dac_gen.sv
// Serial transmitter + data arrange controller top. Optional parity bit per word
// is enabled by defining STI_DAC_PARITY_EN.
module sti_dac_gen
  import sti_dac_gen_pkg::*;
#(
  parameter int DIN_W      = 16,
  parameter int MAX_BYTES  = 4,
  parameter int NUM_PAGES  = 4,
  parameter int PAGE_BYTES = 64,
  parameter int ROW_BYTES  = 8
) (
  input  logic         clk,
  input  logic         reset,
  sti_dac_gen_if.slave bus
);
  localparam int NMAX   = MAX_BYTES * BYTE_W;
  localparam int WW     = (NMAX > DIN_W) ? NMAX : DIN_W;
  localparam int CNT_W  = $clog2(NMAX + 1);
  localparam int IDX_W  = $clog2(NMAX);
  localparam int ADDR_W = $clog2(PAGE_BYTES / 2);
`ifdef STI_DAC_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t            state_reg, state_next;
  logic              run_reg;
  logic [NMAX-1:0]   word_reg;
  logic [CNT_W-1:0]  len_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              msb_reg;
  logic [WW-1:0]     data_ext, form_w;
  int unsigned       n_bits;
  logic [CNT_W-1:0]  last_idx;
  logic [IDX_W-1:0]  bit_idx;
  logic              last_cycle, ready, accept, end_req, last_write;
  logic              so_valid_c, so_parity_c, so_data_c;

  assign last_idx   = len_reg + CNT_W'(PAR_EN);
  assign last_cycle = (cnt_reg == last_idx);
  assign ready      = run_reg && !last_write &&
                      (state_reg == IDLE || (state_reg == SHIFT && last_cycle));
  assign accept     = bus.load && ready;
  assign end_req    = ready && !bus.load && bus.pi_end;

  // Shape the incoming word into the N-bit vector that gets serialised.
  always_comb begin
    n_bits   = byte_bits(32'(bus.pi_length));
    data_ext = WW'(bus.pi_data);
    form_w   = data_ext;
    if (n_bits > DIN_W)
      form_w = bus.pi_fill ? (data_ext << (n_bits - DIN_W)) : data_ext;
    else if (n_bits < DIN_W)
      form_w = bus.pi_low ? (data_ext & ((WW'(1) << n_bits) - WW'(1)))
                          : (data_ext >> (DIN_W - n_bits));
  end

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = SHIFT;
               else if (end_req) state_next = FILL;
      SHIFT:   if (last_write) state_next = DONE;
               else if (last_cycle) state_next = accept ? SHIFT : (end_req ? FILL : IDLE);
      FILL:    if (last_write) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    so_valid_c  = (state_reg == SHIFT);
    so_parity_c = PAR_EN && so_valid_c && last_cycle;
    bit_idx     = msb_reg ? IDX_W'(len_reg - cnt_reg) : IDX_W'(cnt_reg);
    so_data_c   = so_valid_c && (so_parity_c ? ^word_reg : word_reg[bit_idx]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_reg  <= 1'b0;
      word_reg <= '0;
      len_reg  <= '0;
      cnt_reg  <= '0;
      msb_reg  <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (accept) begin
        word_reg <= form_w[NMAX-1:0];
        len_reg  <= CNT_W'(n_bits - 1);
        cnt_reg  <= '0;
        msb_reg  <= bus.pi_msb;
      end else if (state_reg == SHIFT) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.pi_ready  = ready;
  assign bus.so_valid  = so_valid_c;
  assign bus.so_parity = so_parity_c;
  assign bus.so_data   = so_data_c;

  sti_dac_gen_arrange #(
    .NUM_PAGES (NUM_PAGES),
    .PAGE_BYTES(PAGE_BYTES),
    .ROW_BYTES (ROW_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_arrange (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (so_valid_c && !so_parity_c),
    .bit_data  (so_data_c),
    .fill      (state_reg == FILL),
    .clear     (end_req),
    .done      (state_reg == DONE),
    .dataout   (bus.oem_dataout),
    .addr      (bus.oem_addr),
    .wr        (bus.oem_wr),
    .finish    (bus.oem_finish),
    .last_write(last_write)
  );

endmodule

// File: tb/tb_sti_dac_gen.sv
// Self-checking bench for sti_dac_gen: scoreboard of expected serial bits and bank writes.
`timescale 1ns/1ps
module tb_sti_dac_gen;
  localparam int DIN_W = 16, MAX_BYTES = 4, NUM_PAGES = 4, PAGE_BYTES = 64, ROW_BYTES = 8;
  localparam int TOTAL = NUM_PAGES * PAGE_BYTES;
`ifdef STI_DAC_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sti_dac_gen_if #(.DIN_W(DIN_W), .MAX_BYTES(MAX_BYTES), .NUM_PAGES(NUM_PAGES),
                   .PAGE_BYTES(PAGE_BYTES)) sti ();

  sti_dac_gen #(.DIN_W(DIN_W), .MAX_BYTES(MAX_BYTES), .NUM_PAGES(NUM_PAGES),
                .PAGE_BYTES(PAGE_BYTES), .ROW_BYTES(ROW_BYTES))
    dut (.clk(clk), .reset(reset), .bus(sti));

  typedef struct packed { logic b; logic par; } sbit_t;
  typedef struct packed { logic [15:0] g; logic [7:0] data; } wr_t;

  sbit_t exp_bits[$];
  wr_t   exp_wr[$];
  int    errors = 0, checks = 0;
  int    g_model = 0, acc_n = 0, valid_gaps = 0;
  logic  [7:0] acc = '0;
  logic  track_gaps = 1'b0;

  task automatic model_byte(input logic [7:0] d);
    wr_t e;
    if (g_model < TOTAL) begin
      e.g = 16'(g_model); e.data = d;
      exp_wr.push_back(e);
      g_model++;
    end
  endtask

  // Reference: build the N-bit word from the field rules, emit it bit by bit.
  task automatic model_word(input logic [15:0] data, input int len, input logic fill,
                            input logic msb, input logic low);
    int n;
    logic [63:0] w, d64;
    sbit_t s;
    n = (len + 1) * 8;
    d64 = 64'(data);
    if (n == DIN_W) w = d64;
    else if (n > DIN_W) w = fill ? (d64 << (n - DIN_W)) : d64;
    else w = low ? (d64 % (64'd1 << n)) : (d64 / (64'd1 << (DIN_W - n)));
    for (int k = 0; k < n; k++) begin
      if (g_model >= TOTAL) return;
      s.b = msb ? w[n-1-k] : w[k]; s.par = 1'b0;
      exp_bits.push_back(s);
      acc = {acc[6:0], s.b};
      acc_n++;
      if (acc_n == 8) begin model_byte(acc); acc_n = 0; end
    end
    if (PAR != 0 && g_model < TOTAL) begin
      s.b = ^w; s.par = 1'b1;
      exp_bits.push_back(s);
    end
  endtask

  task automatic model_clear();
    exp_bits.delete(); exp_wr.delete();
    g_model = 0; acc_n = 0; acc = '0;
  endtask

  always @(negedge clk) begin
    sbit_t eb;
    wr_t ew;
    int p, i, r, c;
    logic [7:0] es;
    if (reset) begin
      if (track_gaps && !sti.so_valid && exp_bits.size() > 0) valid_gaps++;
      if (sti.so_valid) begin
        checks++;
        if (exp_bits.size() == 0) begin
          errors++;
          $display("FAIL so_stream: so_valid=1 so_data=%b but no bit required at %0t", sti.so_data, $time);
        end else begin
          eb = exp_bits.pop_front();
          if (sti.so_data !== eb.b || sti.so_parity !== eb.par) begin
            errors++;
            $display("FAIL so_stream: so_data=%b so_parity=%b, required %b/%b at %0t",
                     sti.so_data, sti.so_parity, eb.b, eb.par, $time);
          end
        end
      end
      if (sti.oem_wr !== '0) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL oem_write: oem_wr=%b unexpected at %0t", sti.oem_wr, $time);
        end else begin
          ew = exp_wr.pop_front();
          p = int'(ew.g) / PAGE_BYTES; i = int'(ew.g) % PAGE_BYTES;
          r = i / ROW_BYTES; c = i % ROW_BYTES;
          es = 8'd1 << (2 * p + ((r + c) % 2));
          if (sti.oem_wr !== es || sti.oem_addr !== 5'(i / 2) || sti.oem_dataout !== ew.data) begin
            errors++;
            $display("FAIL oem_write g=%0d: wr=%b addr=%0d data=%h, required wr=%b addr=%0d data=%h",
                     ew.g, sti.oem_wr, sti.oem_addr, sti.oem_dataout, es, i / 2, ew.data);
          end
        end
      end
    end
  end

  // Entry/exit point of every stimulus task: 1ns after a rising edge.
  task automatic send_word(input logic [15:0] data, input int len, input logic fill,
                           input logic msb, input logic low, input logic endflag);
    int t = 0;
    while (sti.pi_ready !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    checks++;
    if (sti.pi_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: pi_ready=%b after %0d cycles, required 1", sti.pi_ready, t);
    end
    sti.load = 1'b1; sti.pi_data = data; sti.pi_length = 2'(len);
    sti.pi_fill = fill; sti.pi_msb = msb; sti.pi_low = low; sti.pi_end = endflag;
    @(posedge clk);
    if (sti.pi_ready === 1'b1) model_word(data, len, fill, msb, low);
    #1;
    sti.load = 1'b0; sti.pi_end = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_bits.size() > 0 || exp_wr.size() > 0) && t < 600) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sti.load = 0; sti.pi_data = '0; sti.pi_length = '0; sti.pi_fill = 0;
    sti.pi_msb = 0; sti.pi_low = 0; sti.pi_end = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sti.pi_ready, sti.so_valid, sti.so_data, sti.so_parity, sti.oem_finish} !== 5'b0 ||
        sti.oem_wr !== '0 || sti.oem_dataout !== '0 || sti.oem_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b wr=%b data=%h addr=%0d finish=%b, required all 0",
               sti.pi_ready, sti.so_valid, sti.oem_wr, sti.oem_dataout, sti.oem_addr, sti.oem_finish);
    end
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (sti.pi_ready !== 1'b0) begin errors++; $display("FAIL reset_release: pi_ready=%b, required 0", sti.pi_ready); end
    @(posedge clk); #1;
    checks++;
    if (sti.pi_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: pi_ready=%b, required 1", sti.pi_ready); end
  endtask

  task automatic test_basic();
    int nt = 16 + PAR;
    send_word(16'hA5C3, 1, 1'b0, 1'b1, 1'b0, 1'b1);  // pi_end with load: load wins
    for (int k = 1; k <= nt; k++) begin
      checks++;
      if (sti.so_valid !== 1'b1 || sti.pi_ready !== (k == nt)) begin
        errors++;
        $display("FAIL basic_timing k=%0d: so_valid=%b pi_ready=%b, required 1/%b",
                 k, sti.so_valid, sti.pi_ready, (k == nt));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sti.so_valid !== 1'b0 || sti.pi_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: so_valid=%b pi_ready=%b, required 0/1", sti.so_valid, sti.pi_ready);
    end
    wait_drain();
    checks++;
    if (exp_bits.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: %0d bits %0d writes outstanding, required 0", exp_bits.size(), exp_wr.size());
    end
  endtask

  task automatic test_ignore_load();
    send_word(16'h5A3C, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    sti.load = 1'b1; sti.pi_data = 16'hFFFF; sti.pi_length = 2'd3;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (sti.pi_ready !== 1'b0) begin errors++; $display("FAIL ignore_ready k=%0d: pi_ready=%b, required 0", k, sti.pi_ready); end
      @(posedge clk); #1;
    end
    sti.load = 1'b0;
    wait_drain();
    checks++;
    if (exp_bits.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL ignore_drain: %0d bits %0d writes outstanding, required 0", exp_bits.size(), exp_wr.size());
    end
  endtask

  task automatic test_formats();
    send_word(16'h1234, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    send_word(16'h1234, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(16'hBEEF, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(16'hBEEF, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(16'h0007, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_drain();
    checks++;
    if (exp_bits.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL formats_drain: %0d bits %0d writes outstanding, required 0", exp_bits.size(), exp_wr.size());
    end
  endtask

  task automatic test_back_to_back();
    valid_gaps = 0;
    track_gaps = 1'b1;
    for (int w = 0; w < 16; w++)
      send_word(16'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    wait_drain();
    track_gaps = 1'b0;
    checks++;
    if (valid_gaps != 0) begin errors++; $display("FAIL back_to_back_gaps: %0d idle cycles, required 0", valid_gaps); end
    for (int w = 0; w < 8; w++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_word(16'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
    wait_drain();
    checks++;
    if (exp_bits.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL random_drain: %0d bits %0d writes outstanding, required 0", exp_bits.size(), exp_wr.size());
    end
  endtask

  task automatic test_fill_end();
    int t = 0, run = 0;
    logic early = 1'b0;
    reset = 1'b0; @(posedge clk); #1; model_clear(); reset = 1'b1;
    @(posedge clk); #1;
    send_word(16'($urandom), 2, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    wait_drain();
    sti.pi_end = 1'b1;
    @(posedge clk);
    acc_n = 0;
    while (g_model < TOTAL) model_byte(8'h00);
    #1; sti.pi_end = 1'b0;
    @(negedge clk);
    while (sti.oem_wr === '0 && t < 10) begin @(negedge clk); t++; end
    while (sti.oem_wr !== '0 && run < 300) begin
      if (sti.oem_finish !== 1'b0) early = 1'b1;
      run++;
      @(negedge clk);
    end
    checks++;
    if (run != TOTAL - 3) begin errors++; $display("FAIL fill_count: %0d consecutive writes, required %0d", run, TOTAL - 3); end
    checks++;
    if (early) begin errors++; $display("FAIL fill_early_finish: oem_finish=1 during fill, required 0"); end
    checks++;
    if (sti.oem_finish !== 1'b1) begin errors++; $display("FAIL fill_finish: oem_finish=%b after last write, required 1", sti.oem_finish); end
    @(posedge clk); #1;
    sti.load = 1'b1; sti.pi_data = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (sti.pi_ready !== 1'b0 || sti.so_valid !== 1'b0 || sti.oem_finish !== 1'b1) begin
        errors++;
        $display("FAIL done_hold k=%0d: pi_ready=%b so_valid=%b finish=%b, required 0/0/1",
                 k, sti.pi_ready, sti.so_valid, sti.oem_finish);
      end
    end
    @(posedge clk); #1; sti.load = 1'b0;
    checks++;
    if (exp_wr.size() != 0) begin errors++; $display("FAIL fill_drain: %0d writes outstanding, required 0", exp_wr.size()); end
  endtask

  task automatic test_reset_mid_shift();
    reset = 1'b0; @(posedge clk); #1; model_clear(); reset = 1'b1;
    @(posedge clk); #1;
    send_word(16'hC0DE, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #1; reset = 1'b0;
    @(posedge clk); #1;
    model_clear();
    checks++;
    if ({sti.pi_ready, sti.so_valid, sti.so_data, sti.so_parity, sti.oem_finish} !== 5'b0 ||
        sti.oem_wr !== '0 || sti.oem_dataout !== '0 || sti.oem_addr !== '0) begin
      errors++;
      $display("FAIL midshift_reset: ready=%b valid=%b wr=%b data=%h finish=%b, required all 0",
               sti.pi_ready, sti.so_valid, sti.oem_wr, sti.oem_dataout, sti.oem_finish);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sti.pi_ready !== 1'b1) begin errors++; $display("FAIL midshift_ready: pi_ready=%b, required 1", sti.pi_ready); end
  endtask

  task automatic test_full();
    int t = 0;
    for (int w = 0; w < TOTAL / 4; w++)
      send_word(16'($urandom), 3, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    while (sti.oem_finish !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    checks++;
    if (sti.oem_finish !== 1'b1 || sti.pi_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_finish: oem_finish=%b pi_ready=%b, required 1/0", sti.oem_finish, sti.pi_ready);
    end
    checks++;
    if (exp_bits.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL full_drain: %0d bits %0d writes outstanding, required 0", exp_bits.size(), exp_wr.size());
    end
    sti.load = 1'b1;
    repeat (3) @(posedge clk);
    #1; sti.load = 1'b0;
    checks++;
    if (sti.so_valid !== 1'b0) begin errors++; $display("FAIL full_ignore: so_valid=%b, required 0", sti.so_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_load();
    test_formats();
    test_back_to_back();
    test_fill_end();
    test_reset_mid_shift();
    test_full();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
